multicycle_controller: RTL and testbench

Main control FSM for the multicycle RV32I core variant. It sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction. It drives every datapath select and write strobe from the opcode held in the instruction register, stalling on a memory ready handshake. It supports the same instruction set as the single-cycle opcode decoder: lw, sw, R-type, I-type ALU, beq, jal and lui. `imm_src_o` uses the shared `imm_src_t` encodings.

---
 rtl/multicycle_controller.sv | 215 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller.sv
// multicycle_controller
//   Main control FSM for the multicycle RV32I core. Sequences the shared ALU,
//   the unified instruction/data memory port and the register file across
//   several cycles per instruction, stalling on mem_ready_i.
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   op_i[6:0]        opcode from the instruction register
//   mem_ready_i      memory completes the current access this cycle
//   mem_req_o        memory access requested
//   adr_src_o        address select: 0 = PC, 1 = ALU result register
//   mem_write_o      store strobe
//   ir_write_o       load IR and old-PC register
//   pc_write_o       unconditional PC write
//   branch_o         PC write if ALU zero
//   reg_write_o      register-file write
//   result_src_o[1:0]  00 ALU result reg, 01 mem data reg, 10 ALU output
//   alu_src_a_o[1:0]   00 PC, 01 old PC, 10 rs1
//   alu_src_b_o[1:0]   00 rs2, 01 immediate, 10 constant 4
//   alu_op_o[1:0]      00 add, 01 sub/compare, 10 funct-decoded, 11 pass B
//   imm_src_o        immediate format (imm_src_t)
//   illegal_o        pulse on unsupported opcode in DECODE
//   instr_done_o     pulse in the last cycle of every instruction

package imm_pkg;
  typedef enum logic [2:0] {
    IMM_I = 3'd0,
    IMM_S = 3'd1,
    IMM_B = 3'd2,
    IMM_U = 3'd3,
    IMM_J = 3'd4
  } imm_src_t;
endpackage

module multicycle_controller
  import imm_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [6:0] op_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       adr_src_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       branch_o,
  output logic       reg_write_o,
  output logic [1:0] result_src_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] alu_op_o,
  output imm_src_t   imm_src_o,
  output logic       illegal_o,
  output logic       instr_done_o
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECR, S_EXECI, S_EXECLUI, S_ALUWB, S_BEQ, S_JAL
  } state_t;

  state_t state, state_nxt;

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    mem_req_o    = 1'b0;
    adr_src_o    = 1'b0;
    mem_write_o  = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    branch_o     = 1'b0;
    reg_write_o  = 1'b0;
    result_src_o = 2'b00;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    alu_op_o     = 2'b00;
    illegal_o    = 1'b0;
    instr_done_o = 1'b0;

    case (state)
      S_FETCH: begin
        // PC + 4 is formed on the ALU output and written straight back.
        mem_req_o    = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        ir_write_o   = mem_ready_i;
        pc_write_o   = mem_ready_i;
        if (mem_ready_i) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        // old PC + imm: branch target lands in the ALU result register.
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b01;
        case (op_i)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_R:         state_nxt = S_EXECR;
          OP_I:         state_nxt = S_EXECI;
          OP_LUI:       state_nxt = S_EXECLUI;
          OP_BEQ:       state_nxt = S_BEQ;
          OP_JAL:       state_nxt = S_JAL;
          default: begin
            state_nxt    = S_FETCH;
            illegal_o    = 1'b1;
            instr_done_o = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        state_nxt   = (op_i == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_o = 1'b1;
        adr_src_o = 1'b1;
        if (mem_ready_i) state_nxt = S_MEMWB;
      end
      S_MEMWB: begin
        result_src_o = 2'b01;
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req_o   = 1'b1;
        adr_src_o   = 1'b1;
        mem_write_o = 1'b1;
        if (mem_ready_i) begin
          instr_done_o = 1'b1;
          state_nxt    = S_FETCH;
        end
      end
      S_EXECR: begin
        alu_src_a_o = 2'b10;
        alu_op_o    = 2'b10;
        state_nxt   = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a_o = 2'b10;
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b10;
        state_nxt   = S_ALUWB;
      end
      S_EXECLUI: begin
        alu_src_b_o = 2'b01;
        alu_op_o    = 2'b11;
        state_nxt   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_BEQ: begin
        // Target precomputed in DECODE sits in the result register.
        alu_src_a_o  = 2'b10;
        alu_op_o     = 2'b01;
        branch_o     = 1'b1;
        instr_done_o = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_JAL: begin
        // PC <- target; old PC + 4 is computed now and written back in ALUWB.
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        pc_write_o  = 1'b1;
        state_nxt   = S_ALUWB;
      end
      default: state_nxt = S_FETCH;
    endcase

    // Reset kills every strobe and parks the selects at their FETCH values,
    // so an instruction caught mid-flight never commits a write.
    if (rst_i) begin
      mem_req_o    = 1'b0;
      adr_src_o    = 1'b0;
      mem_write_o  = 1'b0;
      ir_write_o   = 1'b0;
      pc_write_o   = 1'b0;
      branch_o     = 1'b0;
      reg_write_o  = 1'b0;
      illegal_o    = 1'b0;
      instr_done_o = 1'b0;
      result_src_o = 2'b10;
      alu_src_a_o  = 2'b00;
      alu_src_b_o  = 2'b10;
      alu_op_o     = 2'b00;
    end
  end

  always_comb begin
    case (op_i)
      OP_SW:   imm_src_o = IMM_S;
      OP_BEQ:  imm_src_o = IMM_B;
      OP_JAL:  imm_src_o = IMM_J;
      OP_LUI:  imm_src_o = IMM_U;
      default: imm_src_o = IMM_I;
    endcase
  end

endmodule

// File: tb/tb_multicycle_controller.sv
module tb_multicycle_controller;
  import imm_pkg::*;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_ILL = 7'b1110011;

  typedef struct packed {
    logic       req, adr, mw, irw, pcw, br, rw;
    logic [1:0] rs, sa, sb, aop;
    logic [2:0] imm;
    logic       ill, dn;
  } outs_t;

  typedef struct {
    string       name;
    logic        rst;
    logic [6:0]  op;
    logic        rdy;
    outs_t       exp;
  } row_t;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [6:0] op_i = OP_R;
  logic       mem_ready_i = 1'b0;
  logic       mem_req_o, adr_src_o, mem_write_o, ir_write_o, pc_write_o;
  logic       branch_o, reg_write_o, illegal_o, instr_done_o;
  logic [1:0] result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o;
  imm_src_t   imm_src_o;

  int checks = 0;
  int errors = 0;
  outs_t sb_q[$];
  row_t  tbl[$];

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk_i(clk), .rst_i(rst_i), .op_i(op_i), .mem_ready_i(mem_ready_i),
    .mem_req_o(mem_req_o), .adr_src_o(adr_src_o), .mem_write_o(mem_write_o),
    .ir_write_o(ir_write_o), .pc_write_o(pc_write_o), .branch_o(branch_o),
    .reg_write_o(reg_write_o), .result_src_o(result_src_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .imm_src_o(imm_src_o), .illegal_o(illegal_o), .instr_done_o(instr_done_o)
  );

  // Expected-output builders, one per state as listed in the state table.
  function automatic outs_t o(logic req, adr, mw, irw, pcw, br, rw,
                              logic [1:0] rs, sa, sb, aop, logic [2:0] imm,
                              logic ill, dn);
    outs_t t;
    t = '{req, adr, mw, irw, pcw, br, rw, rs, sa, sb, aop, imm, ill, dn};
    return t;
  endfunction
  function automatic outs_t x_rst(logic [2:0] i);    return o(0,0,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,i,0,0); endfunction
  function automatic outs_t x_fetch(logic r, logic [2:0] i); return o(1,0,0,r,r,0,0,2'b10,2'b00,2'b10,2'b00,i,0,0); endfunction
  function automatic outs_t x_dec(logic [2:0] i);    return o(0,0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,i,0,0); endfunction
  function automatic outs_t x_decill(logic [2:0] i); return o(0,0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,i,1,1); endfunction
  function automatic outs_t x_madr(logic [2:0] i);   return o(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,i,0,0); endfunction
  function automatic outs_t x_mrd(logic [2:0] i);    return o(1,1,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,i,0,0); endfunction
  function automatic outs_t x_mwb(logic [2:0] i);    return o(0,0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,i,0,1); endfunction
  function automatic outs_t x_mwr(logic r, logic [2:0] i); return o(1,1,1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,i,0,r); endfunction
  function automatic outs_t x_exr(logic [2:0] i);    return o(0,0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,i,0,0); endfunction
  function automatic outs_t x_exi(logic [2:0] i);    return o(0,0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,i,0,0); endfunction
  function automatic outs_t x_lui(logic [2:0] i);    return o(0,0,0,0,0,0,0,2'b00,2'b00,2'b01,2'b11,i,0,0); endfunction
  function automatic outs_t x_awb(logic [2:0] i);    return o(0,0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,i,0,1); endfunction
  function automatic outs_t x_beq(logic [2:0] i);    return o(0,0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b01,i,0,1); endfunction
  function automatic outs_t x_jal(logic [2:0] i);    return o(0,0,0,0,1,0,0,2'b00,2'b01,2'b10,2'b00,i,0,0); endfunction

  function automatic row_t r(string n, logic rs, logic [6:0] op, logic rdy, outs_t e);
    row_t t;
    t.name = n; t.rst = rs; t.op = op; t.rdy = rdy; t.exp = e;
    return t;
  endfunction

  // Drive one cycle, queue its expectation, compare on the falling edge.
  task automatic step(input row_t v);
    outs_t got, exp;
    rst_i = v.rst; op_i = v.op; mem_ready_i = v.rdy;
    sb_q.push_back(v.exp);
    @(negedge clk);
    got = '{mem_req_o, adr_src_o, mem_write_o, ir_write_o, pc_write_o, branch_o,
            reg_write_o, result_src_o, alu_src_a_o, alu_src_b_o, alu_op_o,
            imm_src_o, illegal_o, instr_done_o};
    exp = sb_q.pop_front();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", v.name, got, exp);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    // reset
    tbl.push_back(r("reset0", 1, OP_R, 0, x_rst(IMM_I)));
    tbl.push_back(r("reset1", 1, OP_R, 1, x_rst(IMM_I)));
    // R-type, ready tied high: 4 cycles
    tbl.push_back(r("r_fetch",  0, OP_R, 1, x_fetch(1, IMM_I)));
    tbl.push_back(r("r_decode", 0, OP_R, 1, x_dec(IMM_I)));
    tbl.push_back(r("r_exec",   0, OP_R, 1, x_exr(IMM_I)));
    tbl.push_back(r("r_wb",     0, OP_R, 1, x_awb(IMM_I)));
    // lw with 2 FETCH stalls and 3 MEMREAD stalls: 10 cycles
    tbl.push_back(r("lw_fetch_st0", 0, OP_LW, 0, x_fetch(0, IMM_I)));
    tbl.push_back(r("lw_fetch_st1", 0, OP_LW, 0, x_fetch(0, IMM_I)));
    tbl.push_back(r("lw_fetch",     0, OP_LW, 1, x_fetch(1, IMM_I)));
    tbl.push_back(r("lw_decode",    0, OP_LW, 1, x_dec(IMM_I)));
    tbl.push_back(r("lw_memadr",    0, OP_LW, 1, x_madr(IMM_I)));
    tbl.push_back(r("lw_rd_st0",    0, OP_LW, 0, x_mrd(IMM_I)));
    tbl.push_back(r("lw_rd_st1",    0, OP_LW, 0, x_mrd(IMM_I)));
    tbl.push_back(r("lw_rd_st2",    0, OP_LW, 0, x_mrd(IMM_I)));
    tbl.push_back(r("lw_rd",        0, OP_LW, 1, x_mrd(IMM_I)));
    tbl.push_back(r("lw_wb",        0, OP_LW, 1, x_mwb(IMM_I)));
    // sw with 2-cycle ready delay: mem_write high 3 cycles
    tbl.push_back(r("sw_fetch",  0, OP_SW, 1, x_fetch(1, IMM_S)));
    tbl.push_back(r("sw_decode", 0, OP_SW, 1, x_dec(IMM_S)));
    tbl.push_back(r("sw_memadr", 0, OP_SW, 1, x_madr(IMM_S)));
    tbl.push_back(r("sw_wr_st0", 0, OP_SW, 0, x_mwr(0, IMM_S)));
    tbl.push_back(r("sw_wr_st1", 0, OP_SW, 0, x_mwr(0, IMM_S)));
    tbl.push_back(r("sw_wr",     0, OP_SW, 1, x_mwr(1, IMM_S)));
    // beq (3 cycles) then jal (4 cycles)
    tbl.push_back(r("beq_fetch",  0, OP_BEQ, 1, x_fetch(1, IMM_B)));
    tbl.push_back(r("beq_decode", 0, OP_BEQ, 1, x_dec(IMM_B)));
    tbl.push_back(r("beq_exec",   0, OP_BEQ, 1, x_beq(IMM_B)));
    tbl.push_back(r("jal_fetch",  0, OP_JAL, 1, x_fetch(1, IMM_J)));
    tbl.push_back(r("jal_decode", 0, OP_JAL, 1, x_dec(IMM_J)));
    tbl.push_back(r("jal_exec",   0, OP_JAL, 1, x_jal(IMM_J)));
    tbl.push_back(r("jal_wb",     0, OP_JAL, 1, x_awb(IMM_J)));
    // illegal opcode: 2 cycles
    tbl.push_back(r("ill_fetch",  0, OP_ILL, 1, x_fetch(1, IMM_I)));
    tbl.push_back(r("ill_decode", 0, OP_ILL, 1, x_decill(IMM_I)));
    // I-type ALU
    tbl.push_back(r("i_fetch",  0, OP_I, 1, x_fetch(1, IMM_I)));
    tbl.push_back(r("i_decode", 0, OP_I, 1, x_dec(IMM_I)));
    tbl.push_back(r("i_exec",   0, OP_I, 1, x_exi(IMM_I)));
    tbl.push_back(r("i_wb",     0, OP_I, 1, x_awb(IMM_I)));

    @(posedge clk); #1;
    foreach (tbl[i]) step(tbl[i]);

    // Reset during a MEMWRITE stall (ready high in the reset cycle must not
    // complete the store), then lui from a clean FETCH.
    step(r("swr_fetch",  0, OP_SW, 1, x_fetch(1, IMM_S)));
    step(r("swr_decode", 0, OP_SW, 1, x_dec(IMM_S)));
    step(r("swr_memadr", 0, OP_SW, 1, x_madr(IMM_S)));
    step(r("swr_wr_st",  0, OP_SW, 0, x_mwr(0, IMM_S)));
    step(r("swr_reset",  1, OP_SW, 1, x_rst(IMM_S)));
    step(r("lui_fetch",  0, OP_LUI, 1, x_fetch(1, IMM_U)));
    step(r("lui_decode", 0, OP_LUI, 1, x_dec(IMM_U)));
    step(r("lui_exec",   0, OP_LUI, 1, x_lui(IMM_U)));
    step(r("lui_wb",     0, OP_LUI, 1, x_awb(IMM_U)));

    // Reset while FETCH has ready high: no ir/pc write in that cycle.
    step(r("fetch_reset", 1, OP_R, 1, x_rst(IMM_I)));
    step(r("post_reset_fetch_stall", 0, OP_R, 0, x_fetch(0, IMM_I)));

    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries required 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
